display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexed scan controller for the multi-digit 7-segment display. It accepts a 32-bit word from the CPU/bus side through a load handshake and holds it in a shadow register. The word moves to the display register only at a frame boundary, so the display never tears. The controller then steps through the digits at a programmable rate, presenting one hex nibble at a time to the downstream `Decoder7` together with a one-hot digit enable.

## Interface
- `DIGITS`, default 8: number of scanned digits; legal range 1..8.
- `PRESCALE`, default 50000: iCLK cycles per digit slot; legal range ≥2.

- `iCLK` input 1: system clock, rising-edge.
- `iRST` input 1: synchronous, active-high reset.
- `iData` input 32: word to display; digit *i* shows `iData[4i+3:4i]`.
- `iLoad` input 1: load request; accepted only in a cycle where `oReady`=1.
- `oReady` output 1: the shadow register is free and a load will be accepted.
- `oNibble` output 4: hex value for the active digit, fed to `Decoder7`.
- `oDigitEn` output DIGITS: one-hot, active-high; selects the active digit.
- `oBlank` output 1: the active digit must be dark.
- `oFrame` output 1: one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Prescaler `pc` counts 0..PRESCALE-1 and wraps.
  - `tick` = (`pc`==PRESCALE-1).
  - Counter width is `$clog2(PRESCALE)`.
- Digit index `idx` advances on each `tick`: 0 → 1 → … → DIGITS-1 → 0.
- `wrap` = `tick` && (`idx`==DIGITS-1).
- Load handshake:
  - `iLoad`=1 with `oReady`=1: `iData` is captured into `shadow`, and `pending` is set.
  - `oReady` = !`pending`.
  - `iLoad` while `oReady`=0 is ignored; no data is captured and no error is raised.
- Swap: on a `wrap` cycle with `pending` already 1 at that cycle, `disp` ← `shadow` and `pending` clears.
  - A load accepted on the `wrap` cycle itself sets `pending` and is swapped at the following wrap, not the current one.
- Outputs are registered and update on the same edge as `idx`:
  - `oDigitEn` = 1 << next `idx`.
  - `oNibble` = next `disp` nibble for next `idx`, using the post-swap `disp` on a swap edge. Digit 0 of a new frame therefore already shows new data.
  - `oFrame` = registered `wrap`, high for exactly one cycle per frame.
- DIGITS<8: nibbles above DIGITS-1 are stored but never displayed.

## Timing
- Reset values (sync, next edge with `iRST`=1):
  - `pc`=0, `idx`=0, `disp`=0, `shadow`=0, `pending`=0.
  - Outputs: `oReady`=1, `oDigitEn`='b1, `oNibble`=0, `oBlank`=0, `oFrame`=0.
- Reset asserted mid-frame or with a pending load discards the pending data; the display restarts at digit 0 showing 0.
- `iLoad` accepted at edge *n* → `oReady`=0 from edge *n*.
- Swap occurs at the first `wrap` edge after *n*; `oReady`=1 from that edge.
- Worst-case load-to-display latency: DIGITS·PRESCALE+1 cycles.
- Digit slot length is exactly PRESCALE cycles; a frame is exactly DIGITS·PRESCALE cycles.
- No combinational path from inputs to outputs except `oReady` ← `pending`, which is a registered signal.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - `oBlank`=1 for every digit above the most significant non-zero nibble of `disp`, within the DIGITS range.
  - Digit 0 is never blanked, so `disp`=0 shows a single "0".
  - `oBlank` is registered alongside `oNibble`.
- `LEADING_ZERO_BLANK_EN` undefined: `oBlank` is tied to 0 and all DIGITS digits are always lit.

## Test plan
- Reset: hold `iRST` for 3 cycles with `PRESCALE`=4.
  - Outputs must match the reset values.
  - First `oDigitEn` change to 'b10 occurs 4 cycles after `iRST` drops.
- Basic load: `PRESCALE`=4, `DIGITS`=8, load 0x12345678 at cycle 2.
  - `oReady` drops next edge.
  - At the first `oFrame`, `oNibble` sequence over the next frame is 8,7,6,5,4,3,2,1.
  - `oReady` returns to 1 on the swap edge.
- Back-pressure: while `pending`=1, pulse `iLoad` with 0xDEADBEEF.
  - The value is ignored; the display shows the earlier accepted word.
  - `oFrame` period is exactly 32 cycles.
- Load on the wrap cycle: assert `iLoad`=0xAAAA0000 exactly on a `wrap` cycle.
  - The current frame keeps the old data.
  - The new data appears after the following `oFrame`.
- Blanking, `LEADING_ZERO_BLANK_EN` defined: display 0x00000A30.
  - `oBlank`=1 on digits 3..7; digits 0..2 show 0,3,A.
  - With the macro undefined, `oBlank` stays 0.
  - Display 0x00000000 (macro defined): only digit 0 is lit, showing 0.
- Reset mid-operation: assert `iRST` at digit 5 with a load pending.
  - `disp`=0 and `oReady`=1; the scan restarts at digit 0.
  - The discarded word never appears.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a frame-synchronous shadow/display swap.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank digits above the top non-zero nibble.
module display_scan_ctrl #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [31:0]       iData,
  input  logic              iLoad,
  output logic              oReady,
  output logic [3:0]        oNibble,
  output logic [DIGITS-1:0] oDigitEn,
  output logic              oBlank,
  output logic              oFrame
);

  localparam int unsigned PcW  = $clog2(PRESCALE);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PcW-1:0]  PcLast  = PcW'(PRESCALE - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [PcW-1:0]    pc_q, pc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       disp_q, disp_d;
  logic [31:0]       shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [3:0]        nibble_q, nibble_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic              frame_q, frame_d;

  logic tick, wrap, accept, swap;

  always_comb begin
    tick   = (pc_q == PcLast);
    wrap   = tick && (idx_q == IdxLast);
    accept = iLoad && !pending_q;
    // Only a word already pending before this wrap is swapped in.
    swap   = wrap && pending_q;

    pc_d = tick ? '0 : pc_q + 1'b1;

    idx_d = idx_q;
    if (wrap) begin
      idx_d = '0;
    end else if (tick) begin
      idx_d = idx_q + 1'b1;
    end

    shadow_d  = shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (swap) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = iData;
      pending_d = 1'b1;
    end

    // Outputs are computed from next-state so they line up with idx_q after the edge.
    digit_en_d = '0;
    nibble_d   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit_en_d[i] = (idx_d == IdxW'(i));
      if (idx_d == IdxW'(i)) begin
        nibble_d = disp_d[4*i +: 4];
      end
    end

    frame_d = wrap;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pc_q       <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      nibble_q   <= '0;
      digit_en_q <= DIGITS'(1);
      frame_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      nibble_q   <= nibble_d;
      digit_en_q <= digit_en_d;
      frame_q    <= frame_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IdxW-1:0] msd;
  logic            blank_q, blank_d;

  // msd stays 0 for an all-zero word, so digit 0 is never blanked.
  always_comb begin
    msd = '0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (disp_d[4*i +: 4] != 4'h0) begin
        msd = IdxW'(i);
      end
    end
    blank_d = (idx_d > msd);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign oBlank = blank_q;
`else
  assign oBlank = 1'b0;
`endif

  assign oReady   = !pending_q;
  assign oNibble  = nibble_q;
  assign oDigitEn = digit_en_q;
  assign oFrame   = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: arithmetic scan model plus directed literal checks.
module tb_display_scan_ctrl;
  localparam int D = 8;
  localparam int P = 4;
  localparam int F = D * P;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [31:0]  data;
  logic         ready;
  logic [3:0]   nibble;
  logic [D-1:0] digit_en;
  logic         blank;
  logic         frame;

  int errors = 0;
  int checks = 0;

  // Model state: k = edges since reset, position derived from it arithmetically.
  int          k = 0;
  bit          pend = 1'b0;
  logic [31:0] sh = '0;
  logic [31:0] dsp = '0;
  bit          mvalid = 1'b0;

  display_scan_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
    .iCLK    (clk),
    .iRST    (rst),
    .iData   (data),
    .iLoad   (load),
    .oReady  (ready),
    .oNibble (nibble),
    .oDigitEn(digit_en),
    .oBlank  (blank),
    .oFrame  (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cur_idx();
    return (k / P) % D;
  endfunction

  function automatic logic exp_blank();
    int msd = 0;
    if (!BlankEn) return 1'b0;
    for (int i = 1; i < D; i++) if (dsp[4*i +: 4] != 4'h0) msd = i;
    return cur_idx() > msd;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k = 0; pend = 0; sh = '0; dsp = '0; mvalid = 1'b1;
    end else if (mvalid) begin
      if ((((k + 1) % F) == 0) && pend) begin
        dsp  = sh;
        pend = 1'b0;
      end else if (load && !pend) begin
        sh   = data;
        pend = 1'b1;
      end
      k = k + 1;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("ready",    32'(ready),    32'(!pend));
      check("digit_en", 32'(digit_en), 32'(1) << cur_idx());
      check("nibble",   32'(nibble),   32'(dsp[4*cur_idx() +: 4]));
      check("frame",    32'(frame),    32'((k > 0) && (k % F == 0)));
      check("blank",    32'(blank),    32'(exp_blank()));
    end
  end

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < 200);
    check("frame_timeout", 32'(frame), 32'(1));
  endtask

  task automatic load_word(input logic [31:0] w);
    load = 1'b1;
    data = w;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; load = 1'b0; data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_digit_en", 32'(digit_en), 32'h1);
    check("rst_nibble",   32'(nibble),   32'h0);
    check("rst_ready",    32'(ready),    32'h1);
    check("rst_frame",    32'(frame),    32'h0);
    check("rst_blank",    32'(blank),    32'h0);
    n = 0;
    while (digit_en != 8'h02 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_step_latency", 32'(n), 32'd4);

    // Basic load plus an ignored back-pressured load.
    load_word(32'h1234_5678);
    check("ready_drop", 32'(ready), 32'h0);
    load_word(32'hDEAD_BEEF);
    wait_frame(n);
    check("ready_at_swap", 32'(ready), 32'h1);
    for (int i = 0; i < D; i++) begin
      check("basic_seq", 32'(nibble), 32'(8 - i));
      repeat (P) @(negedge clk);
    end
    wait_frame(n);
    check("frame_period", 32'(n), 32'd32);

    // Load exactly on the wrap cycle: swapped one frame later.
    n = 0;
    while ((k % F) != F - 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    load_word(32'hAAAA_0000);
    check("wrap_frame", 32'(frame), 32'h1);
    check("wrap_old_d0", 32'(nibble), 32'h8);
    check("wrap_pending", 32'(ready), 32'h0);
    wait_frame(n);
    check("wrap_new_d0", 32'(nibble), 32'h0);
    repeat (4 * P) @(negedge clk);
    check("wrap_new_d4", 32'(nibble), 32'hA);

    // Leading-zero blanking pattern.
    load_word(32'h0000_0A30);
    wait_frame(n);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) check("blank_nib", 32'(nibble), (i == 0) ? 32'h0 : (i == 1) ? 32'h3 : 32'hA);
      check("blank_flag", 32'(blank), 32'((i == 3) && BlankEn));
      repeat (P) @(negedge clk);
    end

    // Reset mid-frame with a pending load.
    wait_frame(n);
    load_word(32'h5555_5555);
    repeat (5 * P - 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 32'(ready), 32'h1);
    check("midrst_en",    32'(digit_en), 32'h1);
    check("midrst_nib",   32'(nibble), 32'h0);
    repeat (2 * F) @(negedge clk);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 999) == 0);
      load = ($urandom_range(0, 3) == 0);
      data = $urandom >> $urandom_range(0, 31);
      @(negedge clk);
    end
    rst = 1'b0; load = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
